// File: rtl/axi_ddr_slave_model.sv
// AXI-style stand-in for a DDR controller port: fixed-length 64-bit bursts into a word RAM,
// with independent write/read engines, programmable read latency, wready gaps and sticky error flags.
module axi_ddr_slave_model #(
    parameter logic [31:0] ADDR_BASE  = 32'h0800_0000,
    parameter int          DEPTH      = 2304,
    parameter int          BURST_LEN  = 256,
    parameter int          RD_LATENCY = 4,
    parameter int          WREADY_GAP = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    output logic        err_addr,
    output logic        err_wlast,
    output logic [15:0] wr_bursts
);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int LW = $clog2(RD_LATENCY) + 1;
    localparam int GW = $clog2(WREADY_GAP + 1) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic       { WI, WD }     wstate_t;
    typedef enum logic [1:0] { RI, RL, RD } rstate_t;

    function automatic logic addrBad(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a[2:0] != 3'd0) || (a < ADDR_BASE) ||
               ((off >> 3) + 32'(BURST_LEN) > 32'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] addrIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return IW'(off >> 3);
    endfunction

    logic [63:0]   mem [DEPTH];

    wstate_t       wstate_q;
    logic [IW-1:0] widx_q;
    logic [BW-1:0] wbeat_q;
    logic [GW-1:0] wgap_q;
    logic          werr_q, awready_q, wready_q, err_wlast_q;
    logic [15:0]   wr_bursts_q;

    rstate_t       rstate_q;
    logic [IW-1:0] ridx_q;
    logic [BW-1:0] rbeat_q;
    logic [LW-1:0] rlat_q;
    logic          rerr_q, arready_q, rvalid_q, rlast_q, err_addr_q;
    logic [63:0]   rdata_q;

    logic          aw_fire_d, ar_fire_d, aw_bad_d, ar_bad_d;
    logic          w_fire_d, w_end_d, w_en_d, r_fire_d;
    logic [IW-1:0] w_addr_d, r_addr_d;
    logic [63:0]   r_word_d;

    assign aw_fire_d = awvalid && awready_q;
    assign ar_fire_d = arvalid && arready_q;
    assign aw_bad_d  = addrBad(awaddr);
    assign ar_bad_d  = addrBad(araddr);
    assign w_fire_d  = (wstate_q == WD) && wvalid && wready_q;
    assign w_end_d   = wlast || (wbeat_q == LAST_BEAT);
    assign w_addr_d  = widx_q + IW'(wbeat_q);
    assign w_en_d    = w_fire_d && !werr_q;
    assign r_fire_d  = (rstate_q == RD) && rvalid_q && rready;
    assign r_addr_d  = (rstate_q == RD) ? ridx_q + IW'(rbeat_q + BW'(1)) : ridx_q;

    // Write-first: a word being written this cycle is forwarded straight into the read register.
    assign r_word_d = rerr_q ? 64'h0 :
                      (w_en_d && (w_addr_d == r_addr_d)) ? wdata : mem[r_addr_d];

    always_ff @(posedge clk) begin
        if (w_en_d)
            mem[w_addr_d] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q    <= WI;
            widx_q      <= '0;
            wbeat_q     <= '0;
            wgap_q      <= '0;
            werr_q      <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            err_wlast_q <= 1'b0;
            wr_bursts_q <= '0;
        end else begin
            case (wstate_q)
                WI: if (aw_fire_d) begin
                    widx_q    <= addrIdx(awaddr);
                    werr_q    <= aw_bad_d;
                    wbeat_q   <= '0;
                    wgap_q    <= '0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    wstate_q  <= WD;
                end
                WD: if (w_fire_d) begin
                    if (wlast != (wbeat_q == LAST_BEAT))
                        err_wlast_q <= 1'b1;
                    if (w_end_d) begin
                        wstate_q    <= WI;
                        wready_q    <= 1'b0;
                        awready_q   <= 1'b1;
                        wr_bursts_q <= wr_bursts_q + 16'd1;
                    end else begin
                        wbeat_q <= wbeat_q + BW'(1);
                        // Insert a one-cycle wready bubble after every WREADY_GAP accepted beats.
                        if (WREADY_GAP > 0 && wgap_q == GW'(WREADY_GAP - 1)) begin
                            wgap_q   <= '0;
                            wready_q <= 1'b0;
                        end else begin
                            wgap_q <= wgap_q + GW'(1);
                        end
                    end
                end else if (!wready_q) begin
                    wready_q <= 1'b1;
                end
                default: wstate_q <= WI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= RI;
            ridx_q    <= '0;
            rbeat_q   <= '0;
            rlat_q    <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                RI: if (ar_fire_d) begin
                    ridx_q    <= addrIdx(araddr);
                    rerr_q    <= ar_bad_d;
                    rbeat_q   <= '0;
                    rlat_q    <= '0;
                    arready_q <= 1'b0;
                    rstate_q  <= RL;
                end
                RL: if (rlat_q == LW'(RD_LATENCY - 1)) begin
                    rstate_q <= RD;
                    rvalid_q <= 1'b1;
                    rdata_q  <= r_word_d;
                    rlast_q  <= (BURST_LEN == 1);
                end else begin
                    rlat_q <= rlat_q + LW'(1);
                end
                RD: if (r_fire_d) begin
                    if (rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= RI;
                    end else begin
                        rbeat_q <= rbeat_q + BW'(1);
                        rdata_q <= r_word_d;
                        rlast_q <= ((rbeat_q + BW'(1)) == LAST_BEAT);
                    end
                end
                default: rstate_q <= RI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_addr_q <= 1'b0;
        else if ((aw_fire_d && aw_bad_d) || (ar_fire_d && ar_bad_d))
            err_addr_q <= 1'b1;
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign arready   = arready_q;
    assign rdata     = rdata_q;
    assign rlast     = rlast_q;
    assign rvalid    = rvalid_q;
    assign err_addr  = err_addr_q;
    assign err_wlast = err_wlast_q;
    assign wr_bursts = wr_bursts_q;
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Scoreboard bench for axi_ddr_slave_model: read expectations are queued at issue time and
// a negedge monitor compares every read beat; a second instance exercises wready gaps.
module tb_axi_ddr_slave_model;
    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam int          DEPTH = 2304;
    localparam int          BL    = 256;

    typedef struct packed { logic [63:0] data; logic last; } beat_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [31:0] awaddr, araddr;
    logic        awvalid, awready, wlast, wvalid, wready, arvalid, arready;
    logic [63:0] wdata, rdata;
    logic        rlast, rvalid, rready, err_addr, err_wlast;
    logic [15:0] wr_bursts;

    logic [31:0] g_awaddr, g_araddr;
    logic        g_awvalid, g_awready, g_wlast, g_wvalid, g_wready, g_arvalid, g_arready;
    logic [63:0] g_wdata, g_rdata;
    logic        g_rlast, g_rvalid, g_rready, g_err_addr, g_err_wlast;
    logic [15:0] g_wr_bursts;

    int          checks = 0, errors = 0, cycle = 0;
    int          hsCycle, firstValidCycle;
    beat_t       expQ[$];
    logic [63:0] model [DEPTH];
    logic        stallPrev = 1'b0, rvalidPrev = 1'b0;
    logic [63:0] prevData;

    axi_ddr_slave_model dut (
        .clk(clk), .rstn(rstn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_addr(err_addr), .err_wlast(err_wlast), .wr_bursts(wr_bursts)
    );

    axi_ddr_slave_model #(.WREADY_GAP(4)) dutGap (
        .clk(clk), .rstn(rstn),
        .awaddr(g_awaddr), .awvalid(g_awvalid), .awready(g_awready),
        .wdata(g_wdata), .wlast(g_wlast), .wvalid(g_wvalid), .wready(g_wready),
        .araddr(g_araddr), .arvalid(g_arvalid), .arready(g_arready),
        .rdata(g_rdata), .rlast(g_rlast), .rvalid(g_rvalid), .rready(g_rready),
        .err_addr(g_err_addr), .err_wlast(g_err_wlast), .wr_bursts(g_wr_bursts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout required handshake (t=%0t)", name, $time);
    endtask

    function automatic logic tbLegal(input logic [31:0] addr);
        return (addr[2:0] == 3'd0) && (addr >= BASE) && (((addr - BASE) >> 3) + 32'(BL) <= 32'(DEPTH));
    endfunction

    function automatic void modelWrite(input logic [31:0] addr, input logic [63:0] base, input int n);
        int idx;
        if (!tbLegal(addr)) return;
        idx = int'((addr - BASE) >> 3);
        for (int k = 0; k < n; k++) model[idx + k] = base + 64'(k);
    endfunction

    task automatic applyReset();
        rstn = 1'b0;
        awvalid = 0; wvalid = 0; wlast = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0;
        g_awvalid = 0; g_wvalid = 0; g_wlast = 0; g_arvalid = 0; g_rready = 0;
        g_awaddr = '0; g_araddr = '0; g_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] base, input int lastAt, input int n);
        int t;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!awready && t < 1000);
        if (!awready) begin failNow("aw_handshake"); awvalid = 0; return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k < n; k++) begin
            wdata = base + 64'(k); wlast = (k == lastAt); wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!wready && t < 1000);
            if (!wready) begin failNow("w_handshake"); wvalid = 0; wlast = 0; return; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic toggle);
        int t, idx;
        beat_t b;
        idx = int'((addr - BASE) >> 3);
        for (int k = 0; k < BL; k++) begin
            b.data = tbLegal(addr) ? model[idx + k] : 64'h0;
            b.last = (k == BL - 1);
            expQ.push_back(b);
        end
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 1000);
        if (!arready) begin failNow("ar_handshake"); arvalid = 0; expQ.delete(); return; end
        hsCycle = cycle + 1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (expQ.size() > 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (toggle) rready = ~rready;
        end
        if (expQ.size() > 0) begin failNow("r_drain"); expQ.delete(); end
        rready = 1'b0;
        checkOutput("rd_latency", 64'(firstValidCycle - hsCycle), 64'd4);
    endtask

    // Read monitor: pops one expectation per accepted beat and checks data hold during stalls.
    always @(negedge clk) begin
        beat_t b;
        if (rstn) begin
            if (rvalid && stallPrev) checkOutput("rdata_hold", rdata, prevData);
            if (rvalid && rready) begin
                if (expQ.size() == 0) failNow("unexpected_rbeat");
                else begin
                    b = expQ.pop_front();
                    checkOutput("rdata", rdata, b.data);
                    checkOutput("rlast", 64'(rlast), 64'(b.last));
                end
            end
            if (rvalid && !rvalidPrev) firstValidCycle = cycle;
        end
        stallPrev  = rvalid && !rready;
        prevData   = rdata;
        rvalidPrev = rvalid;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, beats, gaps, k;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        applyReset();

        // Reset values
        checkOutput("rst_awready", 64'(awready), 64'd1);
        checkOutput("rst_arready", 64'(arready), 64'd1);
        checkOutput("rst_wready", 64'(wready), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rst_rlast", 64'(rlast), 64'd0);
        checkOutput("rst_rdata", rdata, 64'd0);
        checkOutput("rst_err_addr", 64'(err_addr), 64'd0);
        checkOutput("rst_err_wlast", 64'(err_wlast), 64'd0);
        checkOutput("rst_wr_bursts", 64'(wr_bursts), 64'd0);

        // Loopback of one burst
        modelWrite(BASE, 64'd0, BL);
        applyStimulus(BASE, 64'd0, BL - 1, BL);
        checkOutput("loop_wr_bursts", 64'(wr_bursts), 64'd1);
        readBurst(BASE, 1'b0);

        // Full sweep of the RAM
        applyReset();
        for (int b = 0; b < 9; b++) begin
            modelWrite(BASE + 32'(b * 32'h800), 64'hC0DE_0000_0000_0000 + 64'(b * 256), BL);
            applyStimulus(BASE + 32'(b * 32'h800), 64'hC0DE_0000_0000_0000 + 64'(b * 256), BL - 1, BL);
        end
        for (int b = 0; b < 9; b++) readBurst(BASE + 32'(b * 32'h800), 1'b0);
        checkOutput("sweep_err_addr", 64'(err_addr), 64'd0);
        checkOutput("sweep_wr_bursts", 64'(wr_bursts), 64'd9);

        // Back-pressure: toggled rready, then the wready-gap instance
        readBurst(BASE + 32'h1000, 1'b1);
        @(posedge clk); #1;
        g_awaddr = BASE; g_awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!g_awready && t < 100);
        @(posedge clk); #1;
        g_awvalid = 1'b0; g_wvalid = 1'b1;
        beats = 0; gaps = 0; t = 0;
        while (beats < BL && t < 2000) begin
            g_wdata = 64'h5A00 + 64'(beats); g_wlast = (beats == BL - 1);
            @(negedge clk); t++;
            if (g_wready) beats++; else gaps++;
            @(posedge clk); #1;
        end
        g_wvalid = 1'b0; g_wlast = 1'b0;
        checkOutput("gap_beats", 64'(beats), 64'd256);
        // The 64th gap coincides with the end-of-burst deassert, so 63 appear inside the burst.
        checkOutput("gap_count", 64'(gaps), 64'd63);
        checkOutput("gap_wr_bursts", 64'(g_wr_bursts), 64'd1);
        checkOutput("gap_err_wlast", 64'(g_err_wlast), 64'd0);
        g_araddr = BASE; g_arvalid = 1'b1; g_rready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!g_arready && t < 100);
        @(posedge clk); #1;
        g_arvalid = 1'b0;
        k = 0; t = 0;
        while (k < BL && t < 1000) begin
            @(negedge clk); t++;
            if (g_rvalid) begin
                checkOutput("gap_rdata", g_rdata, 64'h5A00 + 64'(k));
                checkOutput("gap_rlast", 64'(g_rlast), 64'(k == BL - 1));
                k++;
            end
        end
        if (k < BL) failNow("gap_read_drain");
        @(posedge clk); #1;
        g_rready = 1'b0;

        // Address and wlast errors
        applyStimulus(BASE + 32'h4800, 64'hDEAD_0000, BL - 1, BL);
        checkOutput("err_addr_set", 64'(err_addr), 64'd1);
        checkOutput("err_wlast_clean", 64'(err_wlast), 64'd0);
        readBurst(BASE + 32'h4000, 1'b0);
        readBurst(BASE + 32'h4800, 1'b0);
        modelWrite(BASE + 32'h800, 64'hBEEF_0000, 101);
        applyStimulus(BASE + 32'h800, 64'hBEEF_0000, 100, 101);
        checkOutput("err_wlast_set", 64'(err_wlast), 64'd1);
        checkOutput("short_awready", 64'(awready), 64'd1);
        checkOutput("short_wready", 64'(wready), 64'd0);
        checkOutput("err_wr_bursts", 64'(wr_bursts), 64'd11);
        readBurst(BASE + 32'h800, 1'b0);

        // Concurrent write and read of the same burst, then reset mid-write
        modelWrite(BASE + 32'h2000, 64'h7700_0000, BL);
        fork
            applyStimulus(BASE + 32'h2000, 64'h7700_0000, BL - 1, BL);
            readBurst(BASE + 32'h2000, 1'b0);
        join
        checkOutput("conc_wr_bursts", 64'(wr_bursts), 64'd12);
        modelWrite(BASE + 32'h3000, 64'h3300_0000, 50);
        applyStimulus(BASE + 32'h3000, 64'h3300_0000, BL - 1, 50);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_awready", 64'(awready), 64'd1);
        checkOutput("midrst_wready", 64'(wready), 64'd0);
        @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_wr_bursts", 64'(wr_bursts), 64'd0);
        checkOutput("midrst_err_addr", 64'(err_addr), 64'd0);
        checkOutput("midrst_err_wlast", 64'(err_wlast), 64'd0);
        modelWrite(BASE + 32'h3800, 64'h9900_0000, BL);
        applyStimulus(BASE + 32'h3800, 64'h9900_0000, BL - 1, BL);
        checkOutput("post_wr_bursts", 64'(wr_bursts), 64'd1);
        readBurst(BASE + 32'h3800, 1'b0);
        readBurst(BASE + 32'h3000, 1'b0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
